// File: rtl/hdmi_acr_pkg.sv
// Shared types, tables and packing helpers for the HDMI ACR packet source.
// Optional CTS averaging is selected with the ACR_CTS_AVERAGE_EN macro in acr_packet_gen.
package hdmi_acr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_MEASURE
    } acr_state_e;

    localparam logic [23:0] ACR_HEADER   = {8'h00, 8'h00, 8'h01};
    localparam logic [2:0]  RATE_DEFAULT = 3'd2;

    // Code 7 is reserved and behaves as 48 kHz.
    function automatic logic [2:0] acr_rate_map(input logic [2:0] rate_sel);
        return (rate_sel == 3'd7) ? RATE_DEFAULT : rate_sel;
    endfunction

    function automatic logic [19:0] acr_n_lookup(input logic [2:0] rate);
        logic [19:0] n_val;
        case (rate)
            3'd0:    n_val = 20'd4096;
            3'd1:    n_val = 20'd6272;
            3'd2:    n_val = 20'd6144;
            3'd3:    n_val = 20'd12544;
            3'd4:    n_val = 20'd12288;
            3'd5:    n_val = 20'd25088;
            3'd6:    n_val = 20'd24576;
            default: n_val = 20'd6144;
        endcase
        return n_val;
    endfunction

    // Window length in audio ticks is N/128.
    function automatic logic [7:0] acr_window_len(input logic [2:0] rate);
        logic [19:0] n_val;
        n_val = acr_n_lookup(rate);
        return n_val[14:7];
    endfunction

    function automatic logic [55:0] acr_pack_subpacket(input logic [19:0] n_val,
                                                       input logic [19:0] cts_val);
        return {n_val[7:0], n_val[15:8], {4'd0, n_val[19:16]},
                cts_val[7:0], cts_val[15:8], {4'd0, cts_val[19:16]}, 8'd0};
    endfunction

endpackage

// File: rtl/acr_packet_gen_if.sv
// Packet handshake between the ACR source (master) and the data-island scheduler (slave).
interface acr_packet_gen_if;

    logic         packet_valid;
    logic         packet_ready;
    logic [23:0]  header;
    logic [223:0] sub;

    modport master (
        output packet_valid,
        output header,
        output sub,
        input  packet_ready
    );

    modport slave (
        input  packet_valid,
        input  header,
        input  sub,
        output packet_ready
    );

endinterface

// File: rtl/acr_window_counter.sv
// Measures one CTS window: counts audio ticks up to the window length and pixel
// cycles between the opening and closing ticks, saturating with an overflow flag.
module acr_window_counter
#(
    parameter int CTS_WIDTH = 20
)
(
    input  logic                 clk_pixel,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 start,
    input  logic                 active,
    input  logic                 audio_tick,
    input  logic [7:0]           win_len,
    output logic                 win_close,
    output logic [CTS_WIDTH-1:0] win_count,
    output logic                 overflow
);

    logic [7:0]           tick_cnt;
    logic [CTS_WIDTH-1:0] cycle_cnt;
    logic                 boundary;

    assign win_close = active && audio_tick && !overflow && (tick_cnt == win_len - 8'd1);
    assign boundary  = start || win_close;
    assign win_count = cycle_cnt;

    // A boundary tick reloads 1, so the closing tick sees the full tick-to-tick interval.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt  <= '0;
            cycle_cnt <= '0;
            overflow  <= 1'b0;
        end else if (clear) begin
            tick_cnt  <= '0;
            cycle_cnt <= '0;
            overflow  <= 1'b0;
        end else if (boundary) begin
            tick_cnt  <= '0;
            cycle_cnt <= CTS_WIDTH'(1);
            overflow  <= 1'b0;
        end else if (active) begin
            if (audio_tick) begin
                tick_cnt <= tick_cnt + 8'd1;
            end
            if (cycle_cnt == '1) begin
                overflow <= 1'b1;
            end else begin
                cycle_cnt <= cycle_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/acr_packet_gen.sv
// HDMI Audio Clock Regeneration packet source: measures CTS and offers the ACR packet.
// Define ACR_CTS_AVERAGE_EN to average 2**AVG_LOG2 windows per published CTS.
module acr_packet_gen
    import hdmi_acr_pkg::*;
#(
    parameter int CTS_WIDTH      = 20,
    parameter int AVG_LOG2       = 2,
    parameter int TIMEOUT_CYCLES = 2**20
)
(
    input  logic                 clk_pixel,
    input  logic                 reset_n,
    input  logic                 audio_tick,
    input  logic [2:0]           rate_sel,
    acr_packet_gen_if.master     pkt,
    output logic [CTS_WIDTH-1:0] cts,
    output logic [CTS_WIDTH-1:0] n,
    output logic                 locked
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    acr_state_e           state_q, state_d;
    logic [2:0]           rate_q, rate_in;
    logic [IDLE_W-1:0]    idle_cnt;
    logic                 rate_change, timeout, abort_sync, clear;
    logic                 win_start, win_active, win_close, overflow;
    logic [7:0]           win_len;
    logic [CTS_WIDTH-1:0] win_count, publish_cts, cts_q, pkt_n;
    logic                 publish, valid_q, locked_q;

    assign rate_in     = acr_rate_map(rate_sel);
    assign rate_change = (rate_in != rate_q);
    assign n           = CTS_WIDTH'(acr_n_lookup(rate_q));
    assign win_len     = acr_window_len(rate_q);
    assign timeout     = !audio_tick && (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));
    assign abort_sync  = rate_change || ((state_q == ST_MEASURE) && overflow);
    assign clear       = abort_sync || timeout;
    assign win_active  = (state_q == ST_MEASURE);
    assign win_start   = (state_q == ST_SYNC) && audio_tick && !clear;

    acr_window_counter #(
        .CTS_WIDTH (CTS_WIDTH)
    ) u_window (
        .clk_pixel  (clk_pixel),
        .reset_n    (reset_n),
        .clear      (clear),
        .start      (win_start),
        .active     (win_active),
        .audio_tick (audio_tick),
        .win_len    (win_len),
        .win_close  (win_close),
        .win_count  (win_count),
        .overflow   (overflow)
    );

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            rate_q   <= RATE_DEFAULT;
            idle_cnt <= '0;
        end else begin
            state_q <= state_d;
            rate_q  <= rate_in;
            if (audio_tick) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IDLE_W'(TIMEOUT_CYCLES)) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

    // Timeout outranks a resync so a silent source always parks in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (audio_tick) state_d = ST_SYNC;
            ST_SYNC:    if (audio_tick) state_d = ST_MEASURE;
            ST_MEASURE: state_d = ST_MEASURE;
            default:    state_d = ST_IDLE;
        endcase
        if (abort_sync) state_d = ST_SYNC;
        if (timeout)    state_d = ST_IDLE;
    end

`ifdef ACR_CTS_AVERAGE_EN
    localparam int ACC_W = CTS_WIDTH + AVG_LOG2;
    localparam int SUM_W = ACC_W + 1;

    logic [ACC_W-1:0]    acc_q;
    logic [AVG_LOG2-1:0] blk_q;
    logic [SUM_W-1:0]    block_sum;

    assign block_sum   = SUM_W'(acc_q) + SUM_W'(win_count) + SUM_W'(1 << (AVG_LOG2 - 1));
    assign publish_cts = CTS_WIDTH'(block_sum >> AVG_LOG2);
    assign publish     = win_close && !clear && (blk_q == '1);

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
            blk_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
            blk_q <= '0;
        end else if (win_close) begin
            if (blk_q == '1) begin
                acc_q <= '0;
                blk_q <= '0;
            end else begin
                acc_q <= acc_q + ACC_W'(win_count);
                blk_q <= blk_q + 1'b1;
            end
        end
    end
`else
    assign publish_cts = win_count;
    assign publish     = win_close && !clear;
`endif

    // A publish wins over a transfer, so the fresh payload is offered next cycle.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            cts_q    <= '0;
            pkt_n    <= CTS_WIDTH'(acr_n_lookup(RATE_DEFAULT));
        end else begin
            if (publish) begin
                valid_q  <= 1'b1;
                locked_q <= 1'b1;
                cts_q    <= publish_cts;
                pkt_n    <= n;
            end else if (valid_q && pkt.packet_ready) begin
                valid_q <= 1'b0;
            end
            if (clear) begin
                locked_q <= 1'b0;
            end
        end
    end

    assign pkt.packet_valid = valid_q;
    assign pkt.header       = ACR_HEADER;
    assign pkt.sub          = {4{acr_pack_subpacket(20'(pkt_n), 20'(cts_q))}};
    assign cts              = cts_q;
    assign locked           = locked_q;

endmodule

// File: tb/tb_acr_packet_gen.sv
// Directed self-checking bench for acr_packet_gen (default build; a short averaging
// sequence is used instead when ACR_CTS_AVERAGE_EN is defined).
module tb_acr_packet_gen;

    localparam int TIMEOUT = 4000;

    localparam logic [55:0] SP_RESET = 56'h00180000000000;
    localparam logic [55:0] SP_W1    = 56'h00180070620000;
    localparam logic [55:0] SP_W4    = 56'h001800700B0000;
    localparam logic [55:0] SP_W7    = 56'h801800660D0000;

    logic        clk_pixel = 1'b0;
    logic        reset_n;
    logic        audio_tick;
    logic [2:0]  rate_sel;
    logic [19:0] cts;
    logic [19:0] n;
    logic        locked;

    int assertCount = 0;
    int failCount   = 0;

    acr_packet_gen_if pkt ();

    acr_packet_gen #(
        .CTS_WIDTH      (20),
        .AVG_LOG2       (2),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk_pixel  (clk_pixel),
        .reset_n    (reset_n),
        .audio_tick (audio_tick),
        .rate_sel   (rate_sel),
        .pkt        (pkt.master),
        .cts        (cts),
        .n          (n),
        .locked     (locked)
    );

    always #5 clk_pixel = ~clk_pixel;

    // Idles gap-1 cycles, then pulses audio_tick for one cycle; returns on the negedge after it.
    task automatic applyStimulus(input int gap);
        audio_tick = 1'b0;
        repeat (gap - 1) @(negedge clk_pixel);
        audio_tick = 1'b1;
        @(negedge clk_pixel);
        audio_tick = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [223:0] observed,
                               input logic [223:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n          = 1'b0;
        audio_tick       = 1'b0;
        rate_sel         = 3'd2;
        pkt.packet_ready = 1'b1;
        repeat (3) @(negedge clk_pixel);

        checkOutput("reset_valid",  pkt.packet_valid, 1'b0);
        checkOutput("reset_cts",    cts, 20'd0);
        checkOutput("reset_locked", locked, 1'b0);
        checkOutput("reset_n_val",  n, 20'd6144);
        checkOutput("reset_header", pkt.header, 24'h000001);
        checkOutput("reset_sub",    pkt.sub, {4{SP_RESET}});
        reset_n = 1'b1;

`ifdef ACR_CTS_AVERAGE_EN
        applyStimulus(100);
        applyStimulus(100);
        for (int w = 0; w < 4; w++) begin
            repeat (47) applyStimulus(100);
            applyStimulus(99 + w);
            if (w < 3) begin
                checkOutput("avg_no_publish", pkt.packet_valid, 1'b0);
                checkOutput("avg_not_locked", locked, 1'b0);
            end
        end
        checkOutput("avg_valid",  pkt.packet_valid, 1'b1);
        checkOutput("avg_cts",    cts, 20'd4801);
        checkOutput("avg_locked", locked, 1'b1);
`else
        applyStimulus(525);
        applyStimulus(525);
        checkOutput("sync_not_locked", locked, 1'b0);
        repeat (47) applyStimulus(525);
        checkOutput("w1_no_early_valid", pkt.packet_valid, 1'b0);
        applyStimulus(525);
        checkOutput("w1_cts",    cts, 20'd25200);
        checkOutput("w1_n",      n, 20'd6144);
        checkOutput("w1_locked", locked, 1'b1);
        checkOutput("w1_valid",  pkt.packet_valid, 1'b1);
        checkOutput("w1_sub",    pkt.sub, {4{SP_W1}});
        @(negedge clk_pixel);
        checkOutput("w1_valid_drop", pkt.packet_valid, 1'b0);

        applyStimulus(99);
        repeat (47) applyStimulus(100);
        checkOutput("w2_cts",    cts, 20'd4800);
        checkOutput("w2_locked", locked, 1'b1);

        pkt.packet_ready = 1'b0;
        repeat (48) applyStimulus(60);
        checkOutput("w3_valid", pkt.packet_valid, 1'b1);
        checkOutput("w3_cts",   cts, 20'd2880);
        repeat (24) applyStimulus(61);
        checkOutput("w4_valid_held", pkt.packet_valid, 1'b1);
        repeat (24) applyStimulus(61);
        checkOutput("w4_valid", pkt.packet_valid, 1'b1);
        checkOutput("w4_cts",   cts, 20'd2928);
        checkOutput("w4_sub",   pkt.sub, {4{SP_W4}});

        repeat (47) applyStimulus(62);
        repeat (61) @(negedge clk_pixel);
        checkOutput("xfer_old_payload", pkt.sub, {4{SP_W4}});
        audio_tick       = 1'b1;
        pkt.packet_ready = 1'b1;
        @(negedge clk_pixel);
        audio_tick = 1'b0;
        checkOutput("xfer_publish_valid", pkt.packet_valid, 1'b1);
        checkOutput("xfer_publish_cts",   cts, 20'd2976);
        @(negedge clk_pixel);
        checkOutput("xfer_valid_drop", pkt.packet_valid, 1'b0);

        repeat (10) applyStimulus(60);
        rate_sel = 3'd1;
        @(negedge clk_pixel);
        checkOutput("rate_n",           n, 20'd6272);
        checkOutput("rate_lock_drop",   locked, 1'b0);
        applyStimulus(100);
        repeat (48) applyStimulus(70);
        checkOutput("rate_partial_discarded", pkt.packet_valid, 1'b0);
        applyStimulus(70);
        checkOutput("w7_valid",  pkt.packet_valid, 1'b1);
        checkOutput("w7_cts",    cts, 20'd3430);
        checkOutput("w7_locked", locked, 1'b1);
        checkOutput("w7_sub",    pkt.sub, {4{SP_W7}});

        repeat (TIMEOUT - 1) @(negedge clk_pixel);
        checkOutput("timeout_locked_before", locked, 1'b1);
        @(negedge clk_pixel);
        checkOutput("timeout_locked_after", locked, 1'b0);
        checkOutput("timeout_no_valid",     pkt.packet_valid, 1'b0);

        pkt.packet_ready = 1'b0;
        applyStimulus(50);
        applyStimulus(50);
        checkOutput("resume_not_locked", locked, 1'b0);
        repeat (48) applyStimulus(80);
        checkOutput("resume_no_early_valid", pkt.packet_valid, 1'b0);
        applyStimulus(80);
        checkOutput("resume_valid",  pkt.packet_valid, 1'b1);
        checkOutput("resume_cts",    cts, 20'd3920);
        checkOutput("resume_locked", locked, 1'b1);

        repeat (5) applyStimulus(80);
        checkOutput("pending_valid", pkt.packet_valid, 1'b1);
        reset_n = 1'b0;
        #2;
        checkOutput("mid_reset_valid",  pkt.packet_valid, 1'b0);
        checkOutput("mid_reset_cts",    cts, 20'd0);
        checkOutput("mid_reset_locked", locked, 1'b0);
        checkOutput("mid_reset_n",      n, 20'd6144);
        checkOutput("mid_reset_sub",    pkt.sub, {4{SP_RESET}});
`endif

        #10;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/acr_packet_gen.md
# acr_packet_gen

Parametrised HDMI Audio Clock Regeneration (ACR) packet source for the HDMI 1.4b data-island path. It measures CTS by counting `clk_pixel` cycles across N/128 audio sample strobes, with N selected at run time from the standard sample-rate family. It presents the finished 4-subpacket ACR packet to the packet scheduler over a valid/ready handshake, and adds lock/timeout supervision plus optional CTS averaging.

## Interface
- `CTS_WIDTH`, 20: CTS/N field width; fixed by HDMI, overridable only for simulation.
- `AVG_LOG2`, 2: log2 of the windows averaged per packet; used only with averaging compiled in.
- `TIMEOUT_CYCLES`, 2**20: `clk_pixel` cycles without `audio_tick` before lock is dropped.
- `clk_pixel` input 1: pixel clock; the only clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `audio_tick` input 1: one-cycle pulse per audio sample, already synchronous to `clk_pixel`.
- `rate_sel` input 3: 0=32k, 1=44.1k, 2=48k, 3=88.2k, 4=96k, 5=176.4k, 6=192k, 7=reserved (treated as 48k).
- `packet_ready` input 1: scheduler accepts packet.
- `packet_valid` output 1: packet available.
- `header` output 24: `{8'h00, 8'h00, 8'h01}`.
- `sub` output 224: four identical 56-bit subpackets; subpacket i occupies `[56*i+55:56*i]`.
- `cts` output 20: last published CTS.
- `n` output 20: N for the registered rate.
- `locked` output 1: measurement valid.

## Operation
- N table: 4096, 6272, 6144, 12544, 12288, 25088, 24576. Window length W = N/128, giving 32, 49, 48, 98, 96, 196, 192 ticks.
- `rate_sel` is registered each cycle. A change of the registered value aborts the current window, clears the accumulator, drops `locked`, and enters SYNC.
- States:
  - IDLE: wait for a tick.
  - SYNC: the first tick starts the window and moves to MEASURE.
  - MEASURE: count cycles and ticks; the tick completing W ticks closes the window and immediately opens the next.
- Cycle counter:
  - Loads 1 at a boundary tick and increments every cycle otherwise.
  - Window count = counter value at the closing tick, so the interval is measured tick-to-tick inclusive of one end.
  - The counter saturates at 2^20−1 and sets an overflow flag. On overflow the window is discarded, `locked` drops, and the block enters SYNC.
- Timeout: the idle counter resets on every tick. When it reaches TIMEOUT_CYCLES the block goes to IDLE, drops `locked`, and clears the accumulator. A pending `packet_valid` is unaffected.
- Publish happens on each completed window (or block of windows, see Configuration). It sets `cts`, sets `locked=1`, and raises `packet_valid`.
- Handshake:
  - A transfer occurs when `packet_valid && packet_ready`; `packet_valid` then falls the next cycle unless a publish occurs that same cycle.
  - A publish while `packet_valid` is high overwrites the payload and keeps `packet_valid` high. The new payload is the one presented next.
  - On simultaneous transfer and publish, the scheduler takes the old payload; the new payload is valid in the following cycle.
- Each subpacket = `{N[7:0], N[15:8], {4'd0, N[19:16]}, cts[7:0], cts[15:8], {4'd0, cts[19:16]}, 8'd0}`.

## Timing
- Reset values:
  - `packet_valid=0`, `cts=0`, `locked=0`, state IDLE.
  - Registered rate = 2, so `n=6144`.
  - `header` is constant.
  - `sub` reflects `n` and `cts=0`.
- Latency: `cts`, `locked` and `packet_valid` update 1 cycle after the closing tick.
- `n` follows `rate_sel` with 1 cycle of latency.
- `audio_tick` high for consecutive cycles counts as consecutive ticks.

## Configuration
- `ACR_CTS_AVERAGE_EN` defined:
  - Window counts are summed over 2^AVG_LOG2 windows.
  - Publish only after the last window of a block, with `cts = (sum + 2^(AVG_LOG2−1)) >> AVG_LOG2`.
  - The accumulator is (20+AVG_LOG2) bits wide.
  - `locked` first rises after the first full block.
- `ACR_CTS_AVERAGE_EN` undefined: every window publishes its raw count, and no accumulator is instantiated.

## Structure
- Package `hdmi_acr_pkg` holds:
  - the state enum;
  - the N and window-length table function indexed by `rate_sel`;
  - the subpacket pack function;
  - the header constant.
- Sub-module `acr_window_counter` contains the tick counter, the saturating cycle counter, the overflow flag and the window-close strobe. The top level holds the FSM, timeout, averaging and handshake.

## Test plan
- Steady 48k, averaging undefined, tick every 525 cycles, `packet_ready=1` → N=6144 and CTS=25200 each window; `locked` high after the first window; `sub` bytes 0x00,0x18,0x00,0x70,0x62,0x00,0x00.
- Handshake:
  - `packet_ready=0` across two windows → `packet_valid` stays high and the payload holds the second CTS.
  - Ready asserted on the cycle of a third publish → old payload taken; `packet_valid` still high the next cycle.
- Change `rate_sel` from 2 to 1 mid-window → `locked` falls, the partial window is discarded, and the next packet has N=6272 with CTS from a fresh 49-tick window.
- Stop ticks → `locked` falls exactly TIMEOUT_CYCLES after the last tick; no new `packet_valid`; resuming ticks yields a publish after SYNC plus one window.
- `ACR_CTS_AVERAGE_EN`, AVG_LOG2=2, window counts 25199/25200/25201/25202 → one publish with CTS=25201 (rounded).
- Assert `reset_n` low mid-window with `packet_valid` high → all outputs return to reset values immediately, with `n=6144`.
